// File: rtl/multicycle_control.sv
// ============================================================================
// multicycle_control: main sequencing FSM of the multicycle MIPS datapath.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_control #(
   parameter logic [5:0] OP_RTYPE = 6'b000000,
   parameter logic [5:0] OP_LW    = 6'b100011,
   parameter logic [5:0] OP_SW    = 6'b101011,
   parameter logic [5:0] OP_BEQ   = 6'b000100,
   parameter logic [5:0] OP_J     = 6'b000010
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] Op,
   input  logic       MemReady,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       MemtoReg,
   output logic       RegDst,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] PCSource,
   output logic [1:0] ALU_OP,
   output logic       Illegal,
   output logic [3:0] State
);

   typedef enum logic [3:0] {
      FETCH     = 4'd0,
      DECODE    = 4'd1,
      MEM_ADDR  = 4'd2,
      MEM_READ  = 4'd3,
      MEM_WB    = 4'd4,
      MEM_WRITE = 4'd5,
      R_EXEC    = 4'd6,
      R_WB      = 4'd7,
      BRANCH    = 4'd8,
      JUMP      = 4'd9
   } state_t;

   state_t     state, next_state;
   logic       is_sw, is_sw_next;
   logic       illegal_next;
   logic       in_fetch;

   logic       pc_write_d, pc_write_cond_d, iord_d, mem_read_d, mem_write_d;
   logic       mem_to_reg_d, reg_dst_d, reg_write_d, alu_src_a_d;
   logic [1:0] alu_src_b_d, pc_source_d, alu_op_d;

   logic       pc_write_q;

   // FETCH only advances once its strobes are live, so a fetch is never lost
   // in the partial cycle between reset release and the first edge.
   always_comb begin
      next_state   = FETCH;
      is_sw_next   = is_sw;
      illegal_next = 1'b0;
      case (state)
         FETCH:     next_state = (MemReady && in_fetch) ? DECODE : FETCH;
         DECODE: begin
            is_sw_next = (Op == OP_SW);
            if (Op == OP_LW || Op == OP_SW) next_state = MEM_ADDR;
            else if (Op == OP_RTYPE)        next_state = R_EXEC;
            else if (Op == OP_BEQ)          next_state = BRANCH;
            else if (Op == OP_J)            next_state = JUMP;
            else begin
               next_state   = FETCH;
               illegal_next = 1'b1;
            end
         end
         MEM_ADDR:  next_state = is_sw ? MEM_WRITE : MEM_READ;
         MEM_READ:  next_state = MemReady ? MEM_WB : MEM_READ;
         MEM_WB:    next_state = FETCH;
         MEM_WRITE: next_state = MemReady ? FETCH : MEM_WRITE;
         R_EXEC:    next_state = R_WB;
         R_WB:      next_state = FETCH;
         BRANCH:    next_state = FETCH;
         JUMP:      next_state = FETCH;
         default:   next_state = FETCH;
      endcase
   end

   // Moore decode of the state being entered; registered below.
   always_comb begin
      pc_write_d      = 1'b0;
      pc_write_cond_d = 1'b0;
      iord_d          = 1'b0;
      mem_read_d      = 1'b0;
      mem_write_d     = 1'b0;
      mem_to_reg_d    = 1'b0;
      reg_dst_d       = 1'b0;
      reg_write_d     = 1'b0;
      alu_src_a_d     = 1'b0;
      alu_src_b_d     = 2'b00;
      pc_source_d     = 2'b00;
      alu_op_d        = 2'b00;
      case (next_state)
         FETCH: begin
            mem_read_d  = 1'b1;
            alu_src_b_d = 2'b01;
            alu_op_d    = 2'b10;
         end
         DECODE: begin
            alu_src_b_d = 2'b11;
            alu_op_d    = 2'b10;
         end
         MEM_ADDR: begin
            alu_src_a_d = 1'b1;
            alu_src_b_d = 2'b10;
            alu_op_d    = is_sw_next ? 2'b01 : 2'b10;
         end
         MEM_READ: begin
            mem_read_d = 1'b1;
            iord_d     = 1'b1;
         end
         MEM_WB: begin
            reg_write_d  = 1'b1;
            mem_to_reg_d = 1'b1;
         end
         MEM_WRITE: begin
            mem_write_d = 1'b1;
            iord_d      = 1'b1;
         end
         R_EXEC:    alu_src_a_d = 1'b1;
         R_WB: begin
            reg_write_d = 1'b1;
            reg_dst_d   = 1'b1;
         end
         BRANCH: begin
            alu_src_a_d     = 1'b1;
            alu_op_d        = 2'b11;
            pc_write_cond_d = 1'b1;
            pc_source_d     = 2'b01;
         end
         JUMP: begin
            pc_write_d  = 1'b1;
            pc_source_d = 2'b10;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= FETCH;
         is_sw       <= 1'b0;
         in_fetch    <= 1'b0;
         Illegal     <= 1'b0;
         pc_write_q  <= 1'b0;
         PCWriteCond <= 1'b0;
         IorD        <= 1'b0;
         MemRead     <= 1'b0;
         MemWrite    <= 1'b0;
         MemtoReg    <= 1'b0;
         RegDst      <= 1'b0;
         RegWrite    <= 1'b0;
         ALUSrcA     <= 1'b0;
         ALUSrcB     <= 2'b00;
         PCSource    <= 2'b00;
         ALU_OP      <= 2'b00;
      end else begin
         state       <= next_state;
         is_sw       <= is_sw_next;
         in_fetch    <= (next_state == FETCH);
         Illegal     <= illegal_next;
         pc_write_q  <= pc_write_d;
         PCWriteCond <= pc_write_cond_d;
         IorD        <= iord_d;
         MemRead     <= mem_read_d;
         MemWrite    <= mem_write_d;
         MemtoReg    <= mem_to_reg_d;
         RegDst      <= reg_dst_d;
         RegWrite    <= reg_write_d;
         ALUSrcA     <= alu_src_a_d;
         ALUSrcB     <= alu_src_b_d;
         PCSource    <= pc_source_d;
         ALU_OP      <= alu_op_d;
      end
   end

   // IR and PC load in the fetch cycle in which memory delivers the word.
   assign IRWrite = in_fetch & MemReady;
   assign PCWrite = pc_write_q | (in_fetch & MemReady);
   assign State   = state;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// ============================================================================
// tb_multicycle_control: table-driven checker for the multicycle control FSM.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_control;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] Op;
   logic       MemReady;
   logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
   logic       MemtoReg, RegDst, RegWrite, ALUSrcA, Illegal;
   logic [1:0] ALUSrcB, PCSource, ALU_OP;
   logic [3:0] State;

   int n_vec  = 0;
   int n_fail = 0;

   multicycle_control dut (
      .clk(clk), .reset(reset), .Op(Op), .MemReady(MemReady),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
      .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
      .ALU_OP(ALU_OP), .Illegal(Illegal), .State(State)
   );

   always #5 clk = ~clk;

   // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,
   //  RegWrite,ALUSrcA,ALUSrcB,PCSource,ALU_OP,Illegal}
   localparam logic [16:0] E_ZERO  = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_0;
   localparam logic [16:0] E_FWAIT = 17'b0_0_0_1_0_0_0_0_0_0_01_00_10_0;
   localparam logic [16:0] E_FRDY  = 17'b1_0_0_1_0_1_0_0_0_0_01_00_10_0;
   localparam logic [16:0] E_DEC   = 17'b0_0_0_0_0_0_0_0_0_0_11_00_10_0;
   localparam logic [16:0] E_MALW  = 17'b0_0_0_0_0_0_0_0_0_1_10_00_10_0;
   localparam logic [16:0] E_MASW  = 17'b0_0_0_0_0_0_0_0_0_1_10_00_01_0;
   localparam logic [16:0] E_MRD   = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
   localparam logic [16:0] E_MWB   = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
   localparam logic [16:0] E_MWR   = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
   localparam logic [16:0] E_REX   = 17'b0_0_0_0_0_0_0_0_0_1_00_00_00_0;
   localparam logic [16:0] E_RWB   = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
   localparam logic [16:0] E_BR    = 17'b0_1_0_0_0_0_0_0_0_1_00_01_11_0;
   localparam logic [16:0] E_JMP   = 17'b1_0_0_0_0_0_0_0_0_0_00_10_00_0;
   localparam logic [16:0] E_ILL   = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_1;

   typedef struct {
      logic [5:0]  op;
      logic        mr;
      logic [3:0]  st;
      logic [16:0] out;
   } vec_t;

   localparam int NV = 31;
   vec_t vecs [NV];

   function automatic logic [16:0] observed();
      return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
              RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, ALU_OP, Illegal};
   endfunction

   task automatic check(input string name, input logic [3:0] st,
                        input logic [16:0] out);
      n_vec++;
      if (State !== st || observed() !== out || (MemRead && MemWrite) ||
          (RegWrite && MemWrite)) begin
         n_fail++;
         $display("FAIL %s: state=%0d outs=%b, required state=%0d outs=%b",
                  name, State, observed(), st, out);
      end
   endtask

   initial begin
      // reset release (pre-edge), then R-type with an opcode toggle outside DECODE
      vecs[0]  = '{6'h00, 1'b0, 4'd0, E_ZERO};
      vecs[1]  = '{6'h00, 1'b1, 4'd0, E_FRDY};
      vecs[2]  = '{6'h00, 1'b1, 4'd1, E_DEC};
      vecs[3]  = '{6'h3F, 1'b1, 4'd6, E_REX};
      vecs[4]  = '{6'h3F, 1'b1, 4'd7, E_RWB};
      // lw with three wait cycles in MEM_READ
      vecs[5]  = '{6'h23, 1'b1, 4'd0, E_FRDY};
      vecs[6]  = '{6'h23, 1'b1, 4'd1, E_DEC};
      vecs[7]  = '{6'h00, 1'b1, 4'd2, E_MALW};
      vecs[8]  = '{6'h00, 1'b0, 4'd3, E_MRD};
      vecs[9]  = '{6'h00, 1'b0, 4'd3, E_MRD};
      vecs[10] = '{6'h00, 1'b0, 4'd3, E_MRD};
      vecs[11] = '{6'h00, 1'b1, 4'd3, E_MRD};
      vecs[12] = '{6'h00, 1'b1, 4'd4, E_MWB};
      // sw
      vecs[13] = '{6'h2B, 1'b1, 4'd0, E_FRDY};
      vecs[14] = '{6'h2B, 1'b1, 4'd1, E_DEC};
      vecs[15] = '{6'h2B, 1'b1, 4'd2, E_MASW};
      vecs[16] = '{6'h2B, 1'b1, 4'd5, E_MWR};
      // beq, then j
      vecs[17] = '{6'h04, 1'b1, 4'd0, E_FRDY};
      vecs[18] = '{6'h04, 1'b1, 4'd1, E_DEC};
      vecs[19] = '{6'h04, 1'b1, 4'd8, E_BR};
      vecs[20] = '{6'h02, 1'b1, 4'd0, E_FRDY};
      vecs[21] = '{6'h02, 1'b1, 4'd1, E_DEC};
      vecs[22] = '{6'h02, 1'b1, 4'd9, E_JMP};
      // illegal opcode: Illegal pulses during the following FETCH only
      vecs[23] = '{6'h3F, 1'b1, 4'd0, E_FRDY};
      vecs[24] = '{6'h3F, 1'b1, 4'd1, E_DEC};
      vecs[25] = '{6'h00, 1'b0, 4'd0, E_FWAIT | E_ILL};
      vecs[26] = '{6'h00, 1'b0, 4'd0, E_FWAIT};
      // fetch that waits, then beq
      vecs[27] = '{6'h04, 1'b1, 4'd0, E_FRDY};
      vecs[28] = '{6'h04, 1'b1, 4'd1, E_DEC};
      vecs[29] = '{6'h04, 1'b0, 4'd8, E_BR};
      vecs[30] = '{6'h04, 1'b0, 4'd0, E_FWAIT};

      reset = 1'b1; Op = 6'h00; MemReady = 1'b0;
      repeat (3) @(negedge clk);
      #1 check("in_reset", 4'd0, E_ZERO);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < NV; i++) begin
         if (i > 0) @(negedge clk);
         Op = vecs[i].op;
         MemReady = vecs[i].mr;
         #1 check($sformatf("vec%0d", i), vecs[i].st, vecs[i].out);
      end

      // sw stalled in MEM_WRITE, then an asynchronous reset mid-cycle
      @(negedge clk); Op = 6'h2B; MemReady = 1'b1;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk); MemReady = 1'b0;
      #1 check("sw_stall_memwrite", 4'd5, E_MWR);
      #2 reset = 1'b1;
      #1 check("async_reset_memwrite", 4'd0, E_ZERO);
      @(negedge clk);
      #1 check("held_reset", 4'd0, E_ZERO);
      reset = 1'b0;
      @(negedge clk);
      #1 check("first_fetch_after_reset", 4'd0, E_FWAIT);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
